// File: rtl/bus_pkg.sv
// Shared bus types for the two-master Wishbone arbiter: FSM state encoding,
// grant encodings and default bus widths.
package bus_pkg;

  localparam int WB_ADDR_W = 32;
  localparam int WB_DATA_W = 32;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GNT_I = 2'd1,
    ARB_GNT_D = 2'd2
  } arb_state_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_I    = 2'b01;
  localparam logic [1:0] GNT_D    = 2'b10;

endpackage

// File: rtl/wb_arb_timeout.sv
// Stall watchdog for the arbiter: counts strobe cycles without ack/err and
// fires once the owner has waited TIMEOUT_CYCLES cycles. Built only with WB_ARB_TIMEOUT_EN.
`ifdef WB_ARB_TIMEOUT_EN
module wb_arb_timeout #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic stb_i,
  input  logic done_i,
  output logic fire_o
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The count equals the number of earlier stalled strobe cycles, so it
  // reaches CNT_LAST exactly in the TIMEOUT_CYCLES-th stalled cycle.
  always_comb begin
    fire_o = stb_i && !done_i && (cnt_q == CNT_LAST);
    cnt_d  = cnt_q + 1'b1;
    if (!stb_i || done_i || fire_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`endif

// File: rtl/wb_bus_arbiter.sv
// Round-robin ICache/DCache to single Wishbone slave arbiter granting whole transactions.
// Optional stall timeout enabled by defining WB_ARB_TIMEOUT_EN.
module wb_bus_arbiter
  import bus_pkg::*;
#(
  parameter int ADDR_W         = WB_ADDR_W,
  parameter int DATA_W         = WB_DATA_W,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req_i,
  input  logic [ADDR_W-1:0]   i_adr_i,
  output logic [DATA_W-1:0]   i_dat_o,
  output logic                i_ack_o,
  output logic                i_err_o,
  input  logic                d_req_i,
  input  logic                d_we_i,
  input  logic [ADDR_W-1:0]   d_adr_i,
  input  logic [DATA_W-1:0]   d_dat_i,
  input  logic [DATA_W/8-1:0] d_sel_i,
  output logic [DATA_W-1:0]   d_dat_o,
  output logic                d_ack_o,
  output logic                d_err_o,
  output logic                wb_cyc_o,
  output logic                wb_stb_o,
  output logic                wb_we_o,
  output logic [ADDR_W-1:0]   wb_adr_o,
  output logic [DATA_W-1:0]   wb_dat_o,
  output logic [DATA_W/8-1:0] wb_sel_o,
  input  logic [DATA_W-1:0]   wb_dat_i,
  input  logic                wb_ack_i,
  input  logic                wb_err_i,
  output logic [1:0]          grant_o
);

  arb_state_t state_q, state_d;
  logic       last_d_q, last_d_d;
  logic [1:0] grant_q, grant_d;
  logic       owner_i, owner_d;
  logic       stb;
  logic       tmo_fire;

  assign owner_i = (state_q == ARB_GNT_I);
  assign owner_d = (state_q == ARB_GNT_D);
  assign stb     = (owner_i && i_req_i) || (owner_d && d_req_i);

`ifdef WB_ARB_TIMEOUT_EN
  wb_arb_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .stb_i  (stb),
    .done_i (wb_ack_i || wb_err_i),
    .fire_o (tmo_fire)
  );
`else
  assign tmo_fire = 1'b0;
`endif

  // Next-state: D wins a tie unless it owned the bus last; a release or a
  // timeout always passes through IDLE so grants never abut.
  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    grant_d  = grant_q;
    case (state_q)
      ARB_IDLE: begin
        if (d_req_i && (!i_req_i || !last_d_q)) begin
          state_d = ARB_GNT_D;
          grant_d = GNT_D;
        end else if (i_req_i) begin
          state_d = ARB_GNT_I;
          grant_d = GNT_I;
        end
      end
      ARB_GNT_I: begin
        if (!i_req_i || tmo_fire) begin
          state_d  = ARB_IDLE;
          grant_d  = GNT_NONE;
          last_d_d = 1'b0;
        end
      end
      ARB_GNT_D: begin
        if (!d_req_i || tmo_fire) begin
          state_d  = ARB_IDLE;
          grant_d  = GNT_NONE;
          last_d_d = 1'b1;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = GNT_NONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ARB_IDLE;
      last_d_q <= 1'b0;
      grant_q  <= GNT_NONE;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      grant_q  <= grant_d;
    end
  end

  assign grant_o = grant_q;

  always_comb begin
    wb_cyc_o = owner_i || owner_d;
    wb_stb_o = stb;
    wb_we_o  = 1'b0;
    wb_adr_o = '0;
    wb_dat_o = '0;
    wb_sel_o = '0;
    if (owner_i) begin
      wb_adr_o = i_adr_i;
      wb_sel_o = '1;
    end else if (owner_d) begin
      wb_we_o  = d_we_i;
      wb_adr_o = d_adr_i;
      wb_dat_o = d_dat_i;
      wb_sel_o = d_sel_i;
    end
  end

  // Responses gate on the owner's strobe, so anything arriving in IDLE is dropped.
  always_comb begin
    i_dat_o = wb_dat_i;
    d_dat_o = wb_dat_i;
    i_ack_o = owner_i && wb_ack_i && stb;
    d_ack_o = owner_d && wb_ack_i && stb;
    i_err_o = owner_i && stb && (wb_err_i || tmo_fire);
    d_err_o = owner_d && stb && (wb_err_i || tmo_fire);
  end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Self-checking bench for wb_bus_arbiter; covers the timeout path when
// WB_ARB_TIMEOUT_EN is defined (bench uses TIMEOUT_CYCLES=8).
module tb_wb_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req_i;
  logic [31:0] i_adr_i;
  logic [31:0] i_dat_o;
  logic        i_ack_o, i_err_o;
  logic        d_req_i, d_we_i;
  logic [31:0] d_adr_i, d_dat_i;
  logic [3:0]  d_sel_i;
  logic [31:0] d_dat_o;
  logic        d_ack_o, d_err_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i, wb_err_i;
  logic [1:0]  grant_o;

  int total = 0;
  int bad   = 0;

  // Response record: {port[1:0] (01 I, 10 D), err, 5'b0, data[31:0]}
  logic [39:0] exp_q[$];

  wb_bus_arbiter #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req_i(i_req_i), .i_adr_i(i_adr_i), .i_dat_o(i_dat_o),
    .i_ack_o(i_ack_o), .i_err_o(i_err_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_adr_i(d_adr_i), .d_dat_i(d_dat_i),
    .d_sel_i(d_sel_i), .d_dat_o(d_dat_o), .d_ack_o(d_ack_o), .d_err_o(d_err_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .grant_o(grant_o)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every ack/err seen at a port must match the queue head.
  always @(negedge clk) begin
    logic [39:0] obs;
    logic [1:0]  port;
    if (!rst && (i_ack_o || i_err_o || d_ack_o || d_err_o)) begin
      port = {d_ack_o | d_err_o, i_ack_o | i_err_o};
      obs  = {port, i_err_o | d_err_o, 5'd0, (port == 2'b01) ? i_dat_o : d_dat_o};
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", {24'd0, obs}, 64'd0);
      end else begin
        chk("resp", {24'd0, obs}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  // Driver: one slave response beat for the given port.
  task automatic beat(input logic [1:0] port, input logic err);
    logic [31:0] d;
    d = $urandom;
    wb_dat_i = d;
    if (err) wb_err_i = 1'b1;
    else     wb_ack_i = 1'b1;
    exp_q.push_back({port, err, 5'd0, d});
    #1;
    if (port == 2'b01) chk("no_cross_d", {62'd0, d_ack_o, d_err_o}, 64'd0);
    else               chk("no_cross_i", {62'd0, i_ack_o, i_err_o}, 64'd0);
    @(posedge clk);
    #1;
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk(tag, {60'd0, grant_o, wb_cyc_o, wb_stb_o}, 64'd0);
  endtask

  initial begin
    rst = 1'b1; i_req_i = 0; i_adr_i = 0; d_req_i = 0; d_we_i = 0;
    d_adr_i = 0; d_dat_i = 0; d_sel_i = 0; wb_dat_i = 0; wb_ack_i = 0; wb_err_i = 0;
    do_reset();
    chk_idle("reset_state");
    chk("reset_resp", {60'd0, i_ack_o, i_err_o, d_ack_o, d_err_o}, 64'd0);

    // I-only read
    i_req_i = 1'b1; i_adr_i = 32'h8000_0000;
    #1;
    chk("i_grant_latency0", {62'd0, grant_o}, 64'd0);
    tick();
    chk("i_grant", {62'd0, grant_o}, 64'd1);
    chk("i_adr", {32'd0, wb_adr_o}, 64'h8000_0000);
    chk("i_we_sel", {59'd0, wb_we_o, wb_sel_o}, 64'h0F);
    chk("i_cyc_stb", {62'd0, wb_cyc_o, wb_stb_o}, 64'd3);
    wb_dat_i = 32'hDEAD_BEEF; wb_ack_i = 1'b1;
    exp_q.push_back({2'b01, 1'b0, 5'd0, 32'hDEAD_BEEF});
    #1;
    chk("i_ack", {62'd0, i_ack_o, d_ack_o}, 64'd2);
    chk("i_dat", {32'd0, i_dat_o}, 64'hDEAD_BEEF);
    tick();
    wb_ack_i = 1'b0;
    i_req_i = 1'b0;
    tick();
    chk_idle("i_release");

    // Simultaneous requests from reset: D, gap, I, gap, D
    do_reset();
    i_req_i = 1'b1; d_req_i = 1'b1; d_adr_i = 32'h40; d_sel_i = 4'h3;
    tick();
    chk("tie_first_d", {62'd0, grant_o}, 64'd2);
    beat(2'b10, 1'b0);
    d_req_i = 1'b0;
    tick();
    chk_idle("handover_gap");
    tick();
    chk("tie_then_i", {62'd0, grant_o}, 64'd1);
    beat(2'b01, 1'b0);
    i_req_i = 1'b0;
    tick();
    chk_idle("i_release2");
    i_req_i = 1'b1; d_req_i = 1'b1;
    tick();
    chk("tie_after_i_d", {62'd0, grant_o}, 64'd2);
    beat(2'b10, 1'b0);
    d_req_i = 1'b0;
    tick();
    chk_idle("d_release2");
    tick();
    chk("pending_i", {62'd0, grant_o}, 64'd1);
    beat(2'b01, 1'b0);
    i_req_i = 1'b0;
    tick();

    // D write burst with I requesting mid-burst
    d_req_i = 1'b1; d_we_i = 1'b1; d_sel_i = 4'hF;
    d_adr_i = 32'h1000; d_dat_i = 32'hA000_0000;
    tick();
    chk("burst_grant", {62'd0, grant_o}, 64'd2);
    for (int k = 0; k < 4; k++) begin
      d_adr_i = 32'h1000 + 32'(4 * k);
      d_dat_i = 32'hA000_0000 + 32'(k);
      if (k == 1) i_req_i = 1'b1;
      #1;
      chk("burst_adr", {32'd0, wb_adr_o}, {32'd0, 32'h1000 + 32'(4 * k)});
      chk("burst_dat", {32'd0, wb_dat_o}, {32'd0, 32'hA000_0000 + 32'(k)});
      chk("burst_ctl", {57'd0, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o}, 64'h7F);
      chk("burst_owner", {62'd0, grant_o}, 64'd2);
      beat(2'b10, 1'b0);
    end
    d_req_i = 1'b0; d_we_i = 1'b0;
    tick();
    chk_idle("burst_release");
    tick();
    chk("after_burst_i", {62'd0, grant_o}, 64'd1);
    beat(2'b01, 1'b0);
    i_req_i = 1'b0;
    tick();

    // Responses while idle are dropped; err during GNT_D holds the grant
    wb_ack_i = 1'b1; wb_err_i = 1'b1;
    #1;
    chk("idle_ack_dropped", {60'd0, i_ack_o, i_err_o, d_ack_o, d_err_o}, 64'd0);
    tick();
    wb_ack_i = 1'b0; wb_err_i = 1'b0;
    d_req_i = 1'b1; d_adr_i = 32'h2000;
    tick();
    beat(2'b10, 1'b1);
    chk("err_grant_held", {62'd0, grant_o}, 64'd2);
    beat(2'b10, 1'b0);
    d_req_i = 1'b0;
    tick();
    chk_idle("err_release");

    // Reset during GNT_I abandons the beat
    i_req_i = 1'b1;
    tick();
    chk("rst_pre_grant", {61'd0, grant_o, wb_stb_o}, 64'd3);
    rst = 1'b1;
    tick();
    chk_idle("rst_mid_txn");
    chk("rst_no_iack", {63'd0, i_ack_o}, 64'd0);
    i_req_i = 1'b0;
    tick();
    rst = 1'b0;
    tick();

`ifdef WB_ARB_TIMEOUT_EN
    // Timeout: stalled D request errors in the 8th strobe cycle
    wb_dat_i = 32'h0BAD_0BAD;
    d_req_i = 1'b1;
    tick();
    for (int c = 1; c <= 8; c++) begin
      if (c == 8) exp_q.push_back({2'b10, 1'b1, 5'd0, 32'h0BAD_0BAD});
      chk("tmo_err", {63'd0, d_err_o}, (c == 8) ? 64'd1 : 64'd0);
      tick();
    end
    d_req_i = 1'b0;
    chk_idle("tmo_idle");
    tick();
`endif

    chk("queue_drain", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
